// File: rtl/scv_vram_arb.sv
// Arbiter sharing one single-port VDC VRAM bank between video fetch (V) and CPU host (C).
// Optional stall statistics: define SCV_VRAM_ARB_STATS_EN to add STALL_CNT / STATS_CLR.
module scv_vram_arb #(
  parameter int unsigned AW         = 12,
  parameter int unsigned DW         = 8,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          CLK,
  input  logic          RESB,
  input  logic          CE,
  input  logic          V_REQ,
  input  logic [AW-1:0] V_A,
  output logic          V_ACK,
  output logic [DW-1:0] V_DO,
  input  logic          C_REQ,
  input  logic          C_WR,
  input  logic [AW-1:0] C_A,
  input  logic [DW-1:0] C_DI,
  output logic          C_ACK,
  output logic [DW-1:0] C_DO,
  output logic [AW-1:0] RAM_A,
  output logic [DW-1:0] RAM_DI,
  input  logic [DW-1:0] RAM_DO,
  output logic          nRAM_CE,
  output logic          nRAM_WE,
  output logic          nRAM_OE
`ifdef SCV_VRAM_ARB_STATS_EN
  ,
  input  logic          STATS_CLR,
  output logic [15:0]   STALL_CNT
`endif
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic            gnt_v_q, gnt_v_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   di_q, di_d;
  logic [DW-1:0]   v_do_q, v_do_d;
  logic [DW-1:0]   c_do_q, c_do_d;
  logic [3:0]      starve_q, starve_d;
  logic            grant_v, grant_c;
  logic            starved;
  logic            access, resp;

  assign starved = (starve_q == StarveMax);

  always_comb begin
    state_d = state_q;
    gnt_v_d = gnt_v_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    di_d    = di_q;
    v_do_d  = v_do_q;
    c_do_d  = c_do_q;
    grant_v = 1'b0;
    grant_c = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (CE) begin
          if (V_REQ && (!C_REQ || !starved)) begin
            grant_v = 1'b1;
          end else if (C_REQ) begin
            grant_c = 1'b1;
          end
        end
        if (grant_v) begin
          state_d = StAccess;
          gnt_v_d = 1'b1;
          wr_d    = 1'b0;
          addr_d  = V_A;
        end else if (grant_c) begin
          // CPU controls are captured once here and ignored for the rest of the access
          state_d = StAccess;
          gnt_v_d = 1'b0;
          wr_d    = C_WR;
          addr_d  = C_A;
          di_d    = C_DI;
        end
      end
      StAccess: state_d = StResp;
      StResp: begin
        state_d = StIdle;
        if (!wr_q) begin
          if (gnt_v_q) v_do_d = RAM_DO;
          else         c_do_d = RAM_DO;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!C_REQ || grant_c) begin
      starve_d = 4'd0;
    end else if (grant_v && !starved) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q  <= StIdle;
      gnt_v_q  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      di_q     <= '0;
      v_do_q   <= '0;
      c_do_q   <= '0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      gnt_v_q  <= gnt_v_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      di_q     <= di_d;
      v_do_q   <= v_do_d;
      c_do_q   <= c_do_d;
      starve_q <= starve_d;
    end
  end

  // Strobes decode straight from state so an async reset releases the RAM at once
  assign access  = (state_q == StAccess);
  assign resp    = (state_q == StResp);
  assign nRAM_CE = !access;
  assign nRAM_OE = !(access && !wr_q);
  assign nRAM_WE = !(access && wr_q);
  assign RAM_A   = access ? addr_q : '0;
  assign RAM_DI  = (access && wr_q) ? di_q : '0;

  assign V_ACK = resp && gnt_v_q;
  assign C_ACK = resp && !gnt_v_q;
  // Registered-read RAM data lands during RESP; pass it through so it is valid with ACK
  assign V_DO  = V_ACK ? RAM_DO : v_do_q;
  assign C_DO  = (C_ACK && !wr_q) ? RAM_DO : c_do_q;

`ifdef SCV_VRAM_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (STATS_CLR) begin
      stall_d = 16'd0;
    end else if (C_REQ && !grant_c && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign STALL_CNT = stall_q;
`endif

endmodule
